// File: rtl/button_conditioner.sv
// Arrow-button front end: per-button 2-FF synchronizer, counter debounce and rising-edge
// pulse, plus a single pending press event handed to the collision stage via valid/ack.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_BITS        = 19
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] btn_raw,
    input  logic       press_ack,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       press_valid,
    output logic [3:0] press_code,
    output logic       press_multi,
    output logic       overrun
);

    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

    logic [3:0]          sync1;
    logic [3:0]          sync2;
    logic [3:0]          levelD;
    logic [CNT_BITS-1:0] cnt [4];
    logic [3:0]          pressIn;
    logic                multiIn;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; this is what makes sync1 -> sync2 a real two-stage chain.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // A level change is accepted only after the synchronized input has disagreed
    // with the stable level for DEBOUNCE_CYCLES consecutive edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_level <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == btn_level[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] < CNT_LAST) begin
                    cnt[i] <= cnt[i] + CNT_BITS'(1);
                end else begin
                    btn_level[i] <= sync2[i];
                    cnt[i]       <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) levelD <= '0;
        else        levelD <= btn_level;
    end

    assign btn_pulse = btn_level & ~levelD;
    assign pressIn   = enable ? btn_pulse : 4'b0000;
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multiIn   = (pressIn & (pressIn - 4'd1)) != 4'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_valid <= 1'b0;
            press_code  <= '0;
            press_multi <= 1'b0;
            overrun     <= 1'b0;
        end else if (press_valid && press_ack) begin
            overrun <= 1'b0;
            if (pressIn != 4'd0) begin
                press_code  <= pressIn;
                press_multi <= multiIn;
            end else begin
                press_valid <= 1'b0;
            end
        end else if (!press_valid && pressIn != 4'd0) begin
            press_valid <= 1'b1;
            press_code  <= pressIn;
            press_multi <= multiIn;
        end else if (press_valid && pressIn != 4'd0) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4; inputs change on the
// falling edge and outputs are checked on the falling edge after each rising edge.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] btn_raw;
    logic       press_ack;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic       press_valid;
    logic [3:0] press_code;
    logic       press_multi;
    logic       overrun;

    int checkCount = 0;
    int passCount  = 0;

    button_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_BITS(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .btn_raw    (btn_raw),
        .press_ack  (press_ack),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .press_valid(press_valid),
        .press_code (press_code),
        .press_multi(press_multi),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Each step covers one rising edge and returns on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, " level"}, {4'd0, btn_level}, 8'h00);
        check({tag, " pulse"}, {4'd0, btn_pulse}, 8'h00);
        check({tag, " valid"}, {7'd0, press_valid}, 8'h00);
        check({tag, " code"},  {4'd0, press_code}, 8'h00);
        check({tag, " multi"}, {7'd0, press_multi}, 8'h00);
        check({tag, " ovr"},   {7'd0, overrun}, 8'h00);
    endtask

    task automatic doReset();
        reset     = 1'b0;
        btn_raw   = 4'b0000;
        press_ack = 1'b0;
        step(2);
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b0;
        btn_raw   = 4'b0000;
        press_ack = 1'b0;
        step(2);
        checkAllZero("reset");
        reset = 1'b1;

        // Clean press on U: level and pulse after edge 5, event after edge 6.
        enable  = 1'b1;
        btn_raw = 4'b0001;
        for (int k = 0; k <= 6; k++) begin
            step(1);
            check($sformatf("clean lvl e%0d", k), {4'd0, btn_level}, (k >= 5) ? 8'h01 : 8'h00);
            check($sformatf("clean pls e%0d", k), {4'd0, btn_pulse}, (k == 5) ? 8'h01 : 8'h00);
            check($sformatf("clean vld e%0d", k), {7'd0, press_valid}, (k >= 6) ? 8'h01 : 8'h00);
        end
        check("clean code",  {4'd0, press_code}, 8'h01);
        check("clean multi", {7'd0, press_multi}, 8'h00);

        // Handshake: one-cycle ack clears valid; ack while idle changes nothing.
        press_ack = 1'b1;
        step(1);
        check("ack valid", {7'd0, press_valid}, 8'h00);
        check("ack code held", {4'd0, press_code}, 8'h01);
        step(1);
        press_ack = 1'b0;
        check("idle ack valid", {7'd0, press_valid}, 8'h00);
        check("idle ack code",  {4'd0, press_code}, 8'h01);
        check("idle ack ovr",   {7'd0, overrun}, 8'h00);

        // Release produces no pulse.
        btn_raw = 4'b0000;
        for (int k = 0; k <= 6; k++) begin
            step(1);
            check($sformatf("release pls e%0d", k), {4'd0, btn_pulse}, 8'h00);
        end
        check("release lvl", {4'd0, btn_level}, 8'h00);

        // Bounce on L: 1,0,1 across edges 0..2 then held; level rises at edge 7.
        doReset();
        btn_raw = 4'b0100;
        step(1);
        btn_raw = 4'b0000;
        step(1);
        btn_raw = 4'b0100;
        for (int k = 2; k <= 8; k++) begin
            step(1);
            check($sformatf("bounce lvl e%0d", k), {4'd0, btn_level}, (k >= 7) ? 8'h04 : 8'h00);
            check($sformatf("bounce pls e%0d", k), {4'd0, btn_pulse}, (k == 7) ? 8'h04 : 8'h00);
        end

        // Overrun then reload with ack coinciding with an R pulse.
        doReset();
        btn_raw = 4'b0001;
        step(7);
        check("ovr pend code", {4'd0, press_code}, 8'h01);
        btn_raw = 4'b1001;
        step(7);
        check("ovr code kept", {4'd0, press_code}, 8'h01);
        check("ovr valid",     {7'd0, press_valid}, 8'h01);
        check("ovr flag",      {7'd0, overrun}, 8'h01);
        btn_raw = 4'b0001;
        step(6);
        check("ovr R released", {4'd0, btn_level}, 8'h01);
        check("ovr sticky",     {7'd0, overrun}, 8'h01);
        btn_raw = 4'b1001;
        step(6);
        check("reload pulse", {4'd0, btn_pulse}, 8'h08);
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        check("reload code",  {4'd0, press_code}, 8'h08);
        check("reload valid", {7'd0, press_valid}, 8'h01);
        check("reload ovr",   {7'd0, overrun}, 8'h00);

        // Enable low: levels track, no event captured.
        doReset();
        enable  = 1'b0;
        btn_raw = 4'b0101;
        step(6);
        check("dis pulse", {4'd0, btn_pulse}, 8'h05);
        step(1);
        check("dis level", {4'd0, btn_level}, 8'h05);
        check("dis valid", {7'd0, press_valid}, 8'h00);

        // U and L together form one multi-button event.
        doReset();
        enable  = 1'b1;
        btn_raw = 4'b0101;
        step(7);
        check("multi valid", {7'd0, press_valid}, 8'h01);
        check("multi code",  {4'd0, press_code}, 8'h05);
        check("multi flag",  {7'd0, press_multi}, 8'h01);

        // Async reset between edges clears everything at once.
        #2;
        reset   = 1'b0;
        btn_raw = 4'b0010;
        #1;
        checkAllZero("async");
        step(2);
        reset = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step(1);
            check($sformatf("held pls e%0d", k), {4'd0, btn_pulse}, (k == 5) ? 8'h02 : 8'h00);
        end
        check("held level", {4'd0, btn_level}, 8'h02);
        check("held code",  {4'd0, press_code}, 8'h02);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
